// File: rtl/sorted_rle_pkg.sv
// Shared types for the sorted-stream run-length compressor.
package sorted_rle_pkg;

  // Default widths, matching the upstream sorter configuration.
  localparam int unsigned RLE_WIDTH = 16;
  localparam int unsigned RLE_CNT_W = 9;

  // Run-tracking states.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // no run open
    ST_RUN   = 2'd1,  // run open, accumulating equal values
    ST_FLUSH = 2'd2   // final run parked, waiting for the output register
  } rle_state_e;

  // One output beat at the default widths.
  typedef struct packed {
    logic [RLE_WIDTH-1:0] value;
    logic [RLE_CNT_W-1:0] count;
    logic                 last;
  } rle_beat_t;

endpackage

// File: rtl/rle_out_reg.sv
// Single-entry valid/ready holding register for the run output.
module rle_out_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              free_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Register can take a new beat when empty or being drained this cycle.
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Next-state: load wins over drain; data holds while stalled.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Holding register flops; reset clears contents so outputs read zero.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/sorted_rle.sv
// Run-length compressor for a sorted packet: one (value,count) beat per run.
module sorted_rle
  import sorted_rle_pkg::*;
#(
  parameter int unsigned WIDTH_P = 16,
  parameter int unsigned CNT_W_P = 9
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [WIDTH_P-1:0] s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic               s_tlast,
  output logic [WIDTH_P-1:0] m_tdata,
  output logic [CNT_W_P-1:0] m_tcount,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic               order_err_o,
  output logic               busy_o
);

  localparam int unsigned BEAT_W = WIDTH_P + CNT_W_P + 1;
  localparam logic [CNT_W_P-1:0] CNT_ONE = CNT_W_P'(1);
  localparam logic [CNT_W_P-1:0] CNT_MAX = '1;

  rle_state_e         state_q, state_d;
  logic [WIDTH_P-1:0] val_q, val_d;
  logic [CNT_W_P-1:0] cnt_q, cnt_d;
  logic [WIDTH_P-1:0] pend_q, pend_d;
  logic               order_err_q, order_err_d;

  logic               out_load;
  logic [BEAT_W-1:0]  out_data_in;
  logic [BEAT_W-1:0]  out_data;
  logic               out_free;
  logic               accept;
  logic               same_run;

  assign s_tready = (state_q != ST_FLUSH) && out_free;
  assign accept   = s_tvalid && s_tready;
  // A beat extends the run only if equal and the count has headroom.
  assign same_run = (s_tdata == val_q) && (cnt_q != CNT_MAX);

  // Run tracking: decide the next run state and what to push to the output.
  always_comb begin
    state_d     = state_q;
    val_d       = val_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    order_err_d = order_err_q;
    out_load    = 1'b0;
    out_data_in = '0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          if (s_tlast) begin
            out_load    = 1'b1;
            out_data_in = {1'b1, CNT_ONE, s_tdata};
          end else begin
            val_d   = s_tdata;
            cnt_d   = CNT_ONE;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (same_run) begin
            if (s_tlast) begin
              out_load    = 1'b1;
              out_data_in = {1'b1, cnt_q + CNT_ONE, val_q};
              state_d     = ST_EMPTY;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            // Close the current run; a smaller value is still taken as a new run.
            if (s_tdata < val_q) order_err_d = 1'b1;
            out_load    = 1'b1;
            out_data_in = {1'b0, cnt_q, val_q};
            if (s_tlast) begin
              pend_d  = s_tdata;
              state_d = ST_FLUSH;
            end else begin
              val_d = s_tdata;
              cnt_d = CNT_ONE;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (out_free) begin
          out_load    = 1'b1;
          out_data_in = {1'b1, CNT_ONE, pend_q};
          state_d     = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Run state, pending-final value and sticky order error.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_EMPTY;
      val_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      order_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      val_q       <= val_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      order_err_q <= order_err_d;
    end
  end

  rle_out_reg #(
    .DATA_W (BEAT_W)
  ) u_out_reg (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .load_i   (out_load),
    .data_i   (out_data_in),
    .ready_i  (m_tready),
    .valid_o  (m_tvalid),
    .data_o   (out_data),
    .free_o   (out_free)
  );

  assign m_tdata     = out_data[WIDTH_P-1:0];
  assign m_tcount    = out_data[WIDTH_P +: CNT_W_P];
  assign m_tlast     = out_data[BEAT_W-1];
  assign order_err_o = order_err_q;
  assign busy_o      = (state_q != ST_EMPTY) || m_tvalid;

endmodule

// File: tb/tb_sorted_rle.sv
// Directed bench for sorted_rle (narrow count width to reach saturation).
module tb_sorted_rle;

  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_ni = 1'b0;
  logic [W-1:0]  s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [W-1:0]  m_tdata;
  logic [CW-1:0] m_tcount;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic          order_err_o;
  logic          busy_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] got[$];
  int pkt[$];

  sorted_rle #(.WIDTH_P(W), .CNT_W_P(CW)) dut (
    .clk_i       (clk),
    .reset_ni    (reset_ni),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tlast     (s_tlast),
    .m_tdata     (m_tdata),
    .m_tcount    (m_tcount),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .order_err_o (order_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int v, input int c, input int l);
    logic [15:0] vv;
    logic [14:0] cc;
    vv = 16'(v);
    cc = 15'(c);
    return {vv, cc, l[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Capture every output handshake; inputs only move just after posedge.
  always @(negedge clk) begin
    if (reset_ni && m_tvalid && m_tready) begin
      got.push_back(mk(int'(m_tdata), int'(m_tcount), int'(m_tlast)));
      $display("beat value=%0d count=%0d last=%0d", m_tdata, m_tcount, m_tlast);
    end
  end

  task automatic send_beat(input int v, input logic l);
    int n;
    n = 0;
    s_tdata  = 16'(v);
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) chk("send_timeout", 32'(s_tready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_pkt();
    for (int i = 0; i < pkt.size(); i++) send_beat(pkt[i], (i == pkt.size() - 1));
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int c;
    c = 0;
    while (got.size() < n && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("beat_count", 32'(got.size()), 32'(n));
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [31:0] exp);
    if (idx < got.size()) chk(tag, got[idx], exp);
    else chk(tag, 32'hdead_beef, exp);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_flags", {28'd0, m_tvalid, m_tlast, order_err_o, busy_o}, 32'd0);
    chk("rst_data", 32'(m_tdata), 32'd0);
    chk("rst_count", 32'(m_tcount), 32'd0);
    @(posedge clk); #1;
    reset_ni = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(s_tready), 32'd1);
    @(posedge clk); #1;

    // 3,3,3,7,9 at full throughput
    got.delete();
    pkt = {3, 3, 3, 7, 9};
    send_pkt();
    wait_beats(3);
    chk_beat("p1_b0", 0, mk(3, 3, 0));
    chk_beat("p1_b1", 1, mk(7, 1, 0));
    chk_beat("p1_b2", 2, mk(9, 1, 1));
    chk("p1_err", 32'(order_err_o), 32'd0);

    // Single beat packet: visible next cycle, busy for exactly one cycle
    got.delete();
    chk("p2_idle_busy", 32'(busy_o), 32'd0);
    send_beat(5, 1'b1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    @(negedge clk);
    chk("p2_valid", {31'd0, m_tvalid}, 32'd1);
    chk("p2_busy_hi", 32'(busy_o), 32'd1);
    @(negedge clk);
    chk("p2_busy_lo", 32'(busy_o), 32'd0);
    wait_beats(1);
    chk_beat("p2_b0", 0, mk(5, 1, 1));

    // Saturation: 20 beats of 4 with a 4-bit count
    got.delete();
    pkt = {};
    for (int i = 0; i < 20; i++) pkt.push_back(4);
    send_pkt();
    wait_beats(2);
    chk_beat("p3_b0", 0, mk(4, 15, 0));
    chk_beat("p3_b1", 1, mk(4, 5, 1));

    // Backpressure with a pending final run
    got.delete();
    m_tready = 1'b0;
    pkt = {1, 1, 2};
    send_pkt();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("p4_hold", mk(int'(m_tdata), int'(m_tcount), int'(m_tlast)), mk(1, 2, 0));
      chk("p4_valid", 32'(m_tvalid), 32'd1);
      chk("p4_sready", 32'(s_tready), 32'd0);
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    wait_beats(2);
    chk_beat("p4_b0", 0, mk(1, 2, 0));
    chk_beat("p4_b1", 1, mk(2, 1, 1));

    // Order error: 8 then 6
    got.delete();
    chk("p5_err_before", 32'(order_err_o), 32'd0);
    pkt = {8, 6};
    send_pkt();
    @(negedge clk);
    chk("p5_err_rise", 32'(order_err_o), 32'd1);
    wait_beats(2);
    chk_beat("p5_b0", 0, mk(8, 1, 0));
    chk_beat("p5_b1", 1, mk(6, 1, 1));
    chk("p5_err_sticky", 32'(order_err_o), 32'd1);

    // Reset mid-packet discards the open run
    got.delete();
    send_beat(5, 1'b0);
    send_beat(5, 1'b0);
    s_tvalid = 1'b0;
    reset_ni = 1'b0;
    @(negedge clk);
    chk("p6_rst_flags", {28'd0, m_tvalid, m_tlast, order_err_o, busy_o}, 32'd0);
    chk("p6_rst_data", {16'd0, m_tdata}, 32'd0);
    @(posedge clk); #1;
    reset_ni = 1'b1;
    @(negedge clk);
    chk("p6_ready", 32'(s_tready), 32'd1);
    @(posedge clk); #1;
    send_beat(9, 1'b1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    wait_beats(1);
    chk_beat("p6_b0", 0, mk(9, 1, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
